// File: rtl/id_ex_imm_ctrl.sv
// rtl/id_ex_imm_ctrl.sv - ID/EX pipeline register with immediate decode, load-use stall and flush
//
// Purpose: decodes the ID-stage instruction (opcode instr[31:26], immediate
// instr[15:0]) into an extended immediate plus control bits, and moves it into
// the ID/EX register under a valid/ready handshake. Load-use hazards and
// taken-branch flushes insert bubbles.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   id_valid, instr   instruction offered by ID
//   id_ready          ID instruction consumed this cycle (combinational)
//   ex_ready          EX accepts the current ID/EX contents
//   flush             branch taken in EX; squash the ID instruction
//   ex_valid          ID/EX entry valid
//   ex_imme           extended immediate
//   ex_ext_mode       0=NONE 1=SIGN 2=ZERO 3=LUI (branches report SIGN)
//   ex_alu_src_imm    ALU B operand is ex_imme
//   ex_mem_read       load
//   ex_mem_write      store
//   ex_branch         beq/bne
//   ex_rs, ex_rt      register fields instr[25:21], instr[20:16]
//   ex_illegal        unsupported opcode
//   hazard_stall      load-use stall active (combinational)

module id_ex_imm_ctrl #(
  parameter int WIDTH_I = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [WIDTH_I-1:0] instr,
  output logic               id_ready,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               ex_valid,
  output logic [WIDTH_I-1:0] ex_imme,
  output logic [1:0]         ex_ext_mode,
  output logic               ex_alu_src_imm,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic               ex_illegal,
  output logic               hazard_stall
);

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_SIGN = 2'd1;
  localparam logic [1:0] MODE_ZERO = 2'd2;
  localparam logic [1:0] MODE_LUI  = 2'd3;

  logic [5:0]         op;
  logic [15:0]        imm;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;

  assign op    = instr[31:26];
  assign imm   = instr[15:0];
  assign id_rs = instr[25:21];
  assign id_rt = instr[20:16];

  logic [WIDTH_I-1:0] d_imme;
  logic [1:0]         d_mode;
  logic               d_alu_src_imm;
  logic               d_mem_read;
  logic               d_mem_write;
  logic               d_branch;
  logic               d_illegal;
  logic               d_uses_rt;

  always_comb begin
    d_imme        = '0;
    d_mode        = MODE_NONE;
    d_alu_src_imm = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_branch      = 1'b0;
    d_illegal     = 1'b0;
    d_uses_rt     = 1'b0;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        d_imme        = {{(WIDTH_I-16){imm[15]}}, imm};
        d_mode        = MODE_SIGN;
        d_alu_src_imm = 1'b1;
        d_mem_read    = (op == 6'h23);
        d_mem_write   = (op == 6'h2B);
        // a store reads rt as its data source
        d_uses_rt     = (op == 6'h2B);
      end
      6'h0C, 6'h0D, 6'h0E: begin
        d_imme        = {{(WIDTH_I-16){1'b0}}, imm};
        d_mode        = MODE_ZERO;
        d_alu_src_imm = 1'b1;
      end
      6'h0F: begin
        d_imme        = {imm, {(WIDTH_I-16){1'b0}}};
        d_mode        = MODE_LUI;
        d_alu_src_imm = 1'b1;
      end
      6'h04, 6'h05: begin
        // word offset: sign-extend then shift left by 2
        d_imme    = {{(WIDTH_I-18){imm[15]}}, imm, 2'b00};
        d_mode    = MODE_SIGN;
        d_branch  = 1'b1;
        d_uses_rt = 1'b1;
      end
      6'h00: begin
        d_uses_rt = 1'b1;
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  logic adv;
  logic rs_match;
  logic rt_match;

  // the register can take new contents whenever EX drains it or it is empty
  assign adv      = ex_ready | ~ex_valid;
  assign rs_match = (id_rs == ex_rt);
  assign rt_match = d_uses_rt & (id_rt == ex_rt);

  assign hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                        (rs_match | rt_match);
  assign id_ready     = adv & ~hazard_stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_imme        <= '0;
      ex_ext_mode    <= MODE_NONE;
      ex_alu_src_imm <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_rs          <= 5'd0;
      ex_rt          <= 5'd0;
      ex_illegal     <= 1'b0;
    end else if (adv) begin
      if (id_valid && !flush && !hazard_stall) begin
        ex_valid       <= 1'b1;
        ex_imme        <= d_imme;
        ex_ext_mode    <= d_mode;
        ex_alu_src_imm <= d_alu_src_imm;
        ex_mem_read    <= d_mem_read;
        ex_mem_write   <= d_mem_write;
        ex_branch      <= d_branch;
        ex_rs          <= id_rs;
        ex_rt          <= id_rt;
        ex_illegal     <= d_illegal;
      end else begin
        // bubble: payload is kept, but side-effecting controls must not
        // look active while the entry is invalid
        ex_valid     <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_imm_ctrl.sv
// tb/tb_id_ex_imm_ctrl.sv - scoreboard testbench for id_ex_imm_ctrl

module tb_id_ex_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] instr;
  logic        id_ready;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_imme;
  logic [1:0]  ex_ext_mode;
  logic        ex_alu_src_imm;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic        ex_illegal;
  logic        hazard_stall;

  id_ex_imm_ctrl #(.WIDTH_I(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .id_ready(id_ready),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_imme(ex_imme),
    .ex_ext_mode(ex_ext_mode), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imme;
    logic [1:0]  mode;
    logic        alu;
    logic        mr;
    logic        mw;
    logic        br;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state: what the ID/EX register should hold
  logic m_valid = 1'b0;
  exp_t m_e     = '0;

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int   op;
    int   s;
    int   u;
    logic [15:0] f;
    f  = ins[15:0];
    op = int'(ins[31:26]);
    s  = int'($signed(f));
    u  = int'(f);
    e  = '0;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    case (op)
      8, 9, 10, 11: begin e.imme = 32'(s); e.mode = 2'd1; e.alu = 1'b1; end
      35:           begin e.imme = 32'(s); e.mode = 2'd1; e.alu = 1'b1; e.mr = 1'b1; end
      43:           begin e.imme = 32'(s); e.mode = 2'd1; e.alu = 1'b1; e.mw = 1'b1; end
      12, 13, 14:   begin e.imme = 32'(u); e.mode = 2'd2; e.alu = 1'b1; end
      15:           begin e.imme = 32'(u * 65536); e.mode = 2'd3; e.alu = 1'b1; end
      4, 5:         begin e.imme = 32'(s * 4); e.mode = 2'd1; e.br = 1'b1; end
      0:            begin end
      default:      e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic bit ref_uses_rt(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    return (op == 0) || (op == 4) || (op == 5) || (op == 43);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one clock of stimulus; inputs change #1 after the rising edge
  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic er, input logic fl, output bit acc);
    exp_t d;
    bit   adv, hz, rdy;
    rst = r; id_valid = iv; instr = ins; ex_ready = er; flush = fl;
    d   = ref_decode(ins);
    adv = er || !m_valid;
    hz  = iv && m_valid && m_e.mr && (m_e.rt != 0) &&
          ((d.rs == m_e.rt) || (ref_uses_rt(ins) && d.rt == m_e.rt));
    rdy = adv && !hz && !fl;
    acc = !r && rdy && iv;
    @(negedge clk);
    if (!r) begin
      chk("id_ready", 64'(id_ready), 64'(rdy));
      chk("hazard_stall", 64'(hazard_stall), 64'(hz));
    end
    if (acc) sb.push_back(d);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_e     = '0;
      sb.delete();
    end else if (adv) begin
      if (acc) begin m_valid = 1'b1; m_e = d; end
      else m_valid = 1'b0;
    end
    #1;
  endtask

  // monitor: every entry EX takes is compared against the oldest prediction
  always @(negedge clk) begin
    exp_t act, e;
    if (rst !== 1'b1) begin
      if (ex_valid && ex_ready) begin
        act = '{imme: ex_imme, mode: ex_ext_mode, alu: ex_alu_src_imm, mr: ex_mem_read,
                mw: ex_mem_write, br: ex_branch, rs: ex_rs, rt: ex_rt, ill: ex_illegal};
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL ex_transfer: got unexpected entry %h expected none", act);
        end else begin
          e = sb.pop_front();
          n_chk++;
          if (act === e) n_pass++;
          else $display("FAIL ex_transfer: got %h expected %h", act, e);
        end
      end else if (ex_valid === 1'b0) begin
        chk("bubble_ctrl", 64'({ex_mem_read, ex_mem_write, ex_branch}), 64'(0));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    int ops[15] = '{0, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 63, 2};
    logic [5:0] op;
    op = 6'(ops[$urandom_range(0, 14)]);
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  initial begin
    bit          acc;
    bit          have;
    logic [31:0] cur;
    rst = 1'b1; id_valid = 1'b0; instr = '0; ex_ready = 1'b1; flush = 1'b0;
    step(1, 0, 32'h0, 1, 0, acc);
    step(1, 0, 32'h0, 1, 0, acc);
    chk("reset_outputs",
        64'({ex_valid, ex_imme, ex_ext_mode, ex_alu_src_imm, ex_mem_read, ex_mem_write,
             ex_branch, ex_rs, ex_rt, ex_illegal}), 64'(0));

    // addi with negative immediate
    step(0, 1, 32'h2108FFFC, 1, 0, acc);
    chk("addi_valid", 64'(ex_valid), 64'(1));
    chk("addi_imme", 64'(ex_imme), 64'h00000000FFFFFFFC);
    chk("addi_mode", 64'(ex_ext_mode), 64'(1));

    // ori / lui / beq back to back
    step(0, 1, 32'h35088000, 1, 0, acc);
    chk("ori_imme", 64'(ex_imme), 64'h0000000000008000);
    step(0, 1, 32'h3C011234, 1, 0, acc);
    chk("lui_imme", 64'(ex_imme), 64'h0000000012340000);
    step(0, 1, 32'h1109FFFF, 1, 0, acc);
    chk("beq_imme", 64'({ex_branch, ex_imme}), 64'h00000001FFFFFFFC);

    // load-use: lw $9 then add reading $9 -> one bubble
    step(0, 1, 32'h8D090004, 1, 0, acc);
    step(0, 1, 32'h01285020, 1, 0, acc);
    chk("lu_bubble", 64'(ex_valid), 64'(0));
    chk("lu_held", 64'(acc), 64'(0));
    step(0, 1, 32'h01285020, 1, 0, acc);
    chk("lu_add_rs", 64'({ex_valid, ex_rs}), 64'({1'b1, 5'd9}));

    // load to $0 never stalls
    step(0, 1, 32'h8C000004, 1, 0, acc);
    step(0, 1, 32'h00005020, 1, 0, acc);
    chk("rt0_no_stall", 64'(ex_valid), 64'(1));

    // EX back-pressure for 3 cycles, flush ignored while holding
    step(0, 1, 32'h2108FFFC, 1, 0, acc);
    step(0, 1, 32'h35088000, 0, 0, acc);
    step(0, 1, 32'h35088000, 0, 1, acc);
    step(0, 1, 32'h35088000, 0, 0, acc);
    chk("hold_valid", 64'({ex_valid, ex_imme}), 64'h00000001FFFFFFFC);
    // flush with EX ready: bubble
    step(0, 1, 32'h35088000, 1, 1, acc);
    chk("flush_bubble", 64'(ex_valid), 64'(0));

    // illegal opcode
    step(0, 1, 32'hFC001234, 1, 0, acc);
    chk("illegal", 64'({ex_illegal, ex_imme}), 64'h0000000100000000);

    // reset mid-stream, then first instruction accepted
    step(0, 1, 32'h8D090004, 0, 0, acc);
    step(1, 1, 32'h01285020, 1, 0, acc);
    chk("midrst_outputs",
        64'({ex_valid, ex_imme, ex_ext_mode, ex_alu_src_imm, ex_mem_read, ex_mem_write,
             ex_branch, ex_rs, ex_rt, ex_illegal}), 64'(0));
    step(0, 1, 32'h01285020, 1, 0, acc);
    chk("post_rst_accept", 64'({acc, ex_valid}), 64'(3));

    // randomized traffic
    have = 1'b0;
    cur  = '0;
    for (int i = 0; i < 600; i++) begin
      bit r, er, fl;
      if (!have) begin
        cur  = rand_instr();
        have = ($urandom_range(0, 9) < 8);
      end
      er = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, have, cur, er, fl, acc);
      if (acc || fl || r) have = 1'b0;
    end

    // drain
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0, acc);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
